// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants shared by the sync generator.
// Derived sync windows and coordinate type live here too.
package vga_timing_pkg;

   localparam int COORD_W   = 10;

   localparam int H_DISPLAY = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int V_DISPLAY = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;

   localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_DISPLAY + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_DISPLAY + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_tick_gen.sv
// Pixel-rate enable: one-clk pulse every CLK_DIV clocks.
// Counter restarts at zero on reset.
module vga_tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic p_tick
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

   logic [DW-1:0] div;

   always_ff @(posedge clk) begin
      if (reset)
         div <= '0;
      else if (div == LAST)
         div <= '0;
      else
         div <= div + 1'b1;
   end

   assign p_tick = (div == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: h/v counters with registered, x/y-aligned syncs.
// Define VGA_FRAME_TICK_EN to build the start-of-frame pulse.
module vga_sync_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
   parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BACK    = vga_timing_pkg::H_BACK,
   parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
   parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick
);

   import vga_timing_pkg::*;

   localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST = coord_t'(HT - 1);
   localparam coord_t V_LAST = coord_t'(VT - 1);
   localparam coord_t H_VIS  = coord_t'(H_DISPLAY - 1);
   localparam coord_t V_VIS  = coord_t'(V_DISPLAY - 1);
   localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   coord_t h, v;
   coord_t h_nxt, v_nxt;

   vga_tick_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .p_tick (p_tick)
   );

   always_comb begin
      h_nxt = h;
      v_nxt = v;
      if (p_tick) begin
         if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h_nxt = h + 1'b1;
         end
      end
   end

   // Syncs decode the next coordinates so they land with x/y.
   always_ff @(posedge clk) begin
      if (reset) begin
         h        <= '0;
         v        <= '0;
         hsync    <= 1'b1;
         vsync    <= 1'b1;
         video_on <= 1'b1;
      end else begin
         h        <= h_nxt;
         v        <= v_nxt;
         hsync    <= !(h_nxt >= HS_LO && h_nxt <= HS_HI);
         vsync    <= !(v_nxt >= VS_LO && v_nxt <= VS_HI);
         video_on <= (h_nxt <= H_VIS) && (v_nxt <= V_VIS);
      end
   end

   assign x = h;
   assign y = v;

`ifdef VGA_FRAME_TICK_EN
   logic frame_wrap;
   logic ft_q;

   assign frame_wrap = p_tick && (h == H_LAST) && (v == V_LAST);

   always_ff @(posedge clk) begin
      if (reset)
         ft_q <= 1'b0;
      else
         ft_q <= frame_wrap;
   end

   assign frame_tick = ft_q;
`else
   assign frame_tick = 1'b0;
`endif

endmodule
